// File: rtl/sign_ext_arb.sv
// sign_ext_arb
//   Two requesters share one registered sign-extension datapath. Each
//   requester offers a raw NB-bit field and a format code. Arbitration is
//   round-robin. The granted field is extended to M bits and held in a
//   one-entry output register that uses a valid/ready handshake.
//
//   Optional build macro: SIGN_EXT_ARB_ZEXT_EN. When it is defined, the
//   block gains per-requester i_reqK_uns inputs and an o_uns output. With
//   uns=1 the upper bits are zero-filled instead of sign-filled.
//
// Ports
//   i_clk, i_rst_n              clock; asynchronous active-low reset
//   i_reqK_valid / o_reqK_ready handshake for requester K (K = 0, 1)
//   i_reqK_x [NB-1:0]           raw field for requester K
//   i_reqK_fmt                  0: extend from bit NA-1, 1: extend from bit NB-1
//   i_reqK_uns                  (macro only) zero-fill instead of sign-fill
//   o_valid / i_ready           result handshake
//   o_y [M-1:0]                 extended result
//   o_id, o_fmt, o_uns          index, format and (macro only) fill mode of the result
module sign_ext_arb #(
  parameter int M  = 32,
  parameter int NA = 12,
  parameter int NB = 20
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req0_valid,
  output logic          o_req0_ready,
  input  logic [NB-1:0] i_req0_x,
  input  logic          i_req0_fmt,
`ifdef SIGN_EXT_ARB_ZEXT_EN
  input  logic          i_req0_uns,
  input  logic          i_req1_uns,
  output logic          o_uns,
`endif
  input  logic          i_req1_valid,
  output logic          o_req1_ready,
  input  logic [NB-1:0] i_req1_x,
  input  logic          i_req1_fmt,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [M-1:0]  o_y,
  output logic          o_id,
  output logic          o_fmt
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t         state_q, state_d;
  logic           ptr_q, ptr_d;
  logic [M-1:0]   y_q, y_d;
  logic           id_q, id_d;
  logic           fmt_q, fmt_d;
  logic           uns_q, uns_d;

  logic           gnt_vld;
  logic           gnt_idx;
  logic           slot_free;
  logic           accept;
  logic [NB-1:0]  sel_x;
  logic           sel_fmt;
  logic           sel_uns;

  // Bits at or above the selected width are filled with either the selected
  // sign bit or zero. The field is widened to M first, so every bit index
  // stays inside the vector even when NB == M.
  function automatic logic [M-1:0] extend(input logic [NB-1:0] x,
                                          input logic          fmt,
                                          input logic          uns);
    logic [M-1:0] xw;
    logic [M-1:0] r;
    logic         fill;
    int           w;
    xw   = M'(x);
    w    = fmt ? NB : NA;
    fill = uns ? 1'b0 : xw[w-1];
    r    = '0;
    for (int i = 0; i < M; i++) begin
      r[i] = (i < w) ? xw[i] : fill;
    end
    return r;
  endfunction

  // If only one requester is valid, it is granted. If both are valid, the
  // pointer decides.
  always_comb begin
    gnt_vld = i_req0_valid | i_req1_valid;
    gnt_idx = (i_req0_valid & i_req1_valid) ? ptr_q : i_req1_valid;
  end

  assign o_valid      = (state_q == ST_FULL);
  assign slot_free    = ~o_valid | i_ready;
  assign accept       = gnt_vld & slot_free;
  assign o_req0_ready = slot_free & gnt_vld & ~gnt_idx;
  assign o_req1_ready = slot_free & gnt_vld &  gnt_idx;

  always_comb begin
    sel_x   = gnt_idx ? i_req1_x   : i_req0_x;
    sel_fmt = gnt_idx ? i_req1_fmt : i_req0_fmt;
`ifdef SIGN_EXT_ARB_ZEXT_EN
    sel_uns = gnt_idx ? i_req1_uns : i_req0_uns;
`else
    sel_uns = 1'b0;
`endif
  end

  // On an accept while FULL with i_ready high, the old result leaves and
  // the new one loads at the same edge, so the slot has no bubble.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    y_d     = y_q;
    id_d    = id_q;
    fmt_d   = fmt_q;
    uns_d   = uns_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (i_ready && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (accept) begin
      y_d   = extend(sel_x, sel_fmt, sel_uns);
      id_d  = gnt_idx;
      fmt_d = sel_fmt;
      uns_d = sel_uns;
      ptr_d = ~gnt_idx;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_EMPTY;
      ptr_q   <= 1'b0;
      y_q     <= '0;
      id_q    <= 1'b0;
      fmt_q   <= 1'b0;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      y_q     <= y_d;
      id_q    <= id_d;
      fmt_q   <= fmt_d;
      uns_q   <= uns_d;
    end
  end

  assign o_y   = y_q;
  assign o_id  = id_q;
  assign o_fmt = fmt_q;
`ifdef SIGN_EXT_ARB_ZEXT_EN
  assign o_uns = uns_q;
`else
  // Without the option, the fill mode is always signed and has no output.
  logic unused_uns;
  assign unused_uns = uns_q;
`endif

endmodule

// File: tb/tb_sign_ext_arb.sv
module tb_sign_ext_arb;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req0_valid = 1'b0, i_req1_valid = 1'b0;
  logic        o_req0_ready, o_req1_ready;
  logic [19:0] i_req0_x = '0, i_req1_x = '0;
  logic        i_req0_fmt = 1'b0, i_req1_fmt = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_y;
  logic        o_id, o_fmt;
`ifdef SIGN_EXT_ARB_ZEXT_EN
  logic        i_req0_uns = 1'b0, i_req1_uns = 1'b0;
  logic        o_uns;
`endif

  sign_ext_arb #(.M(32), .NA(12), .NB(20)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req0_valid (i_req0_valid),
    .o_req0_ready (o_req0_ready),
    .i_req0_x     (i_req0_x),
    .i_req0_fmt   (i_req0_fmt),
`ifdef SIGN_EXT_ARB_ZEXT_EN
    .i_req0_uns   (i_req0_uns),
    .i_req1_uns   (i_req1_uns),
    .o_uns        (o_uns),
`endif
    .i_req1_valid (i_req1_valid),
    .o_req1_ready (o_req1_ready),
    .i_req1_x     (i_req1_x),
    .i_req1_fmt   (i_req1_fmt),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_y          (o_y),
    .o_id         (o_id),
    .o_fmt        (o_fmt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] y;
    logic        id;
    logic        fmt;
  } item_t;

  item_t sb[$];
  logic  m_valid = 1'b0;
  logic  m_ptr   = 1'b0;
  int    n_chk   = 0;
  int    n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_ext(input logic [19:0] x, input logic f);
    return f ? {{12{x[19]}}, x} : {{20{x[11]}}, x[11:0]};
  endfunction

  // Drive inputs for one cycle and check the outputs produced by the
  // previous edge. Then advance the model across the next edge.
  task automatic step(input logic v0, input logic [19:0] x0, input logic f0,
                      input logic v1, input logic [19:0] x1, input logic f1,
                      input logic rdy);
    logic  gv, g, sf, acc;
    item_t it;
    @(negedge i_clk);
    i_req0_valid = v0; i_req0_x = x0; i_req0_fmt = f0;
    i_req1_valid = v1; i_req1_x = x1; i_req1_fmt = f1;
    i_ready = rdy;
    #1;
    gv  = v0 | v1;
    g   = (v0 && v1) ? m_ptr : v1;
    sf  = !m_valid || rdy;
    acc = gv && sf;
    chk("valid", {31'b0, o_valid}, {31'b0, m_valid});
    chk("rdy0", {31'b0, o_req0_ready}, {31'b0, sf && gv && !g});
    chk("rdy1", {31'b0, o_req1_ready}, {31'b0, sf && gv && g});
`ifdef SIGN_EXT_ARB_ZEXT_EN
    chk("uns", {31'b0, o_uns}, 32'd0);
`endif
    if (m_valid) begin
      if (sb.size() == 0) begin
        chk("sb_depth", 32'(sb.size()), 32'd1);
      end else begin
        it = sb[0];
        chk("y",   o_y, it.y);
        chk("id",  {31'b0, o_id},  {31'b0, it.id});
        chk("fmt", {31'b0, o_fmt}, {31'b0, it.fmt});
        if (rdy) void'(sb.pop_front());
      end
    end
    if (acc) begin
      it.y   = g ? m_ext(x1, f1) : m_ext(x0, f0);
      it.id  = g;
      it.fmt = g ? f1 : f0;
      sb.push_back(it);
      m_ptr = !g;
    end
    m_valid = acc || (m_valid && !rdy);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 20'h0, 1'b0, 1'b0, 20'h0, 1'b0, rdy);
  endtask

  task automatic after_edge();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_y", o_y, 32'd0);
    chk("rst_id", {31'b0, o_id}, 32'd0);
    chk("rst_fmt", {31'b0, o_fmt}, 32'd0);
    #11 i_rst_n = 1'b1;

    // Narrow and wide extension, with literal result checks
    step(1'b1, 20'h00800, 1'b0, 1'b0, 20'h0, 1'b0, 1'b1);
    after_edge();
    chk("lit_narrow_neg", o_y, 32'hFFFFF800);
    chk("lit_narrow_id", {31'b0, o_id}, 32'd0);
    step(1'b0, 20'h0, 1'b0, 1'b1, 20'h80000, 1'b1, 1'b1);
    after_edge();
    chk("lit_wide_neg", o_y, 32'hFFF80000);
    chk("lit_wide_id", {31'b0, o_id}, 32'd1);
    step(1'b0, 20'h0, 1'b0, 1'b1, 20'h7FFFF, 1'b1, 1'b1);
    after_edge();
    chk("lit_wide_pos", o_y, 32'h0007FFFF);
    step(1'b1, 20'hFF7FF, 1'b0, 1'b0, 20'h0, 1'b0, 1'b1);
    after_edge();
    chk("lit_narrow_garbage", o_y, 32'h000007FF);
    idle(1'b1);

    // Continuous contention
    for (int i = 0; i < 6; i++)
      step(1'b1, 20'h00100 + 20'(i), 1'b0, 1'b1, 20'hF0000 + 20'(i), 1'b1, 1'b1);
    idle(1'b1);

    // Backpressure with both requesters waiting
    step(1'b1, 20'h00800, 1'b0, 1'b0, 20'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b1, 20'h00123, 1'b0, 1'b1, 20'h80001, 1'b1, 1'b0);
    step(1'b1, 20'h00123, 1'b0, 1'b1, 20'h80001, 1'b1, 1'b1);
    after_edge();
    chk("lit_bp_id", {31'b0, o_id}, 32'd1);
    chk("lit_bp_y", o_y, 32'hFFF80001);
    idle(1'b0);

    // Asynchronous reset while holding a result
    @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, o_valid}, 32'd0);
    chk("arst_y", o_y, 32'd0);
    sb.delete();
    m_valid = 1'b0;
    m_ptr   = 1'b0;
    #3 i_rst_n = 1'b1;
    step(1'b1, 20'h00ABC, 1'b0, 1'b1, 20'h12345, 1'b1, 1'b1);
    after_edge();
    chk("lit_post_rst_id", {31'b0, o_id}, 32'd0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 20'h00ABC ^ 20'(i), 1'b0, 1'b1, 20'h12345 ^ 20'(i), 1'b1, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 20'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 20'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0));
    idle(1'b1);
    idle(1'b1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
